// File: rtl/node_list_walker_pkg.sv
// Shared field layout for the nodeHeads / nodeToElement RAMs and the walker FSM types.
// The builder and walker both import this so the two RAM formats cannot drift apart.
package node_list_walker_pkg;

    localparam int NODE_W  = 5;
    localparam int PTR_W   = 5;
    localparam int COUNT_W = 6;
    localparam int TYPE_W  = 2;
    localparam int VALUE_W = 32;

    // nodeHeads word
    localparam int HEAD_BUILT_BIT = 63;
    localparam int HEAD_PTR_HI    = 46;
    localparam int HEAD_PTR_LO    = 42;

    // nodeToElement word
    localparam int ENT_END_BIT    = 63;
    localparam int ENT_NEXT_HI    = 62;
    localparam int ENT_NEXT_LO    = 58;
    localparam int ENT_IS_B_BIT   = 44;
    localparam int ENT_OTHER_HI   = 43;
    localparam int ENT_OTHER_LO   = 39;
    localparam int ENT_CUR_HI     = 38;
    localparam int ENT_CUR_LO     = 34;
    localparam int ENT_TYPE_HI    = 33;
    localparam int ENT_TYPE_LO    = 32;
    localparam int ENT_VALUE_HI   = 31;
    localparam int ENT_VALUE_LO   = 0;

    typedef enum logic [1:0] {
        ELEM_VSRC = 2'b00,
        ELEM_ISRC = 2'b01,
        ELEM_RES  = 2'b10
    } elem_type_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD_WAIT,
        S_ENTRY_WAIT,
        S_EMIT,
        S_FINISH
    } walk_state_e;

endpackage

// File: rtl/node_list_walker_if.sv
// Element record stream produced by the walker: valid/ready handshake plus record fields.
interface node_list_walker_if;
    import node_list_walker_pkg::*;

    logic               elem_valid;
    logic               elem_ready;
    logic               elem_is_node_B;
    logic [NODE_W-1:0]  elem_other_node;
    logic [TYPE_W-1:0]  elem_type;
    logic [VALUE_W-1:0] elem_value;

    modport master (
        output elem_valid, elem_is_node_B, elem_other_node, elem_type, elem_value,
        input  elem_ready
    );

    modport slave (
        input  elem_valid, elem_is_node_B, elem_other_node, elem_type, elem_value,
        output elem_ready
    );

endinterface

// File: rtl/node_list_walker.sv
// Walks one node's linked element list (nodeHeads -> nodeToElement chain) and streams
// each element record out; read-only on both RAMs.
module node_list_walker
    import node_list_walker_pkg::*;
#(
    parameter int RAM_LAT  = 2,
    parameter int MAX_HOPS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NODE_W-1:0]   node_addr,
    output logic                busy,
    output logic                done,
    output logic                list_empty,
    output logic                walk_error,
    output logic [COUNT_W-1:0]  elem_count,
    output logic [NODE_W-1:0]   nodeHeads_addr,
    output logic                nodeHeads_wren,
    input  logic [63:0]         nodeHeads_out,
    output logic [PTR_W-1:0]    nodeToElement_addr,
    output logic                nodeToElement_wren,
    input  logic [63:0]         nodeToElement_out,
    node_list_walker_if.master  elem
);

    localparam int WAIT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(RAM_LAT - 1);
    localparam logic [COUNT_W-1:0] HOP_LIMIT = COUNT_W'(MAX_HOPS);

    walk_state_e        state, state_nxt;
    logic [NODE_W-1:0]  cur_node, cur_node_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [COUNT_W-1:0] hop, hop_nxt, hop_inc;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [COUNT_W-1:0] count_nxt;
    logic               empty_nxt, error_nxt;
    logic               valid_nxt, is_b_nxt;
    logic [NODE_W-1:0]  other_nxt;
    logic [TYPE_W-1:0]  type_nxt;
    logic [VALUE_W-1:0] value_nxt;
    logic               end_bit, end_bit_nxt;
    logic [PTR_W-1:0]   next_ptr, next_ptr_nxt;

    assign busy               = (state != S_IDLE);
    assign done               = (state == S_FINISH);
    assign nodeHeads_addr     = cur_node;
    assign nodeToElement_addr = ptr;
    assign nodeHeads_wren     = 1'b0;
    assign nodeToElement_wren = 1'b0;
    assign hop_inc            = hop + COUNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= S_IDLE;
            cur_node             <= '0;
            ptr                  <= '0;
            hop                  <= '0;
            wait_cnt             <= '0;
            elem_count           <= '0;
            list_empty           <= 1'b0;
            walk_error           <= 1'b0;
            elem.elem_valid      <= 1'b0;
            elem.elem_is_node_B  <= 1'b0;
            elem.elem_other_node <= '0;
            elem.elem_type       <= '0;
            elem.elem_value      <= '0;
            end_bit              <= 1'b0;
            next_ptr             <= '0;
        end else begin
            state                <= state_nxt;
            cur_node             <= cur_node_nxt;
            ptr                  <= ptr_nxt;
            hop                  <= hop_nxt;
            wait_cnt             <= wait_cnt_nxt;
            elem_count           <= count_nxt;
            list_empty           <= empty_nxt;
            walk_error           <= error_nxt;
            elem.elem_valid      <= valid_nxt;
            elem.elem_is_node_B  <= is_b_nxt;
            elem.elem_other_node <= other_nxt;
            elem.elem_type       <= type_nxt;
            elem.elem_value      <= value_nxt;
            end_bit              <= end_bit_nxt;
            next_ptr             <= next_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_node_nxt = cur_node;
        ptr_nxt      = ptr;
        hop_nxt      = hop;
        wait_cnt_nxt = wait_cnt;
        count_nxt    = elem_count;
        empty_nxt    = list_empty;
        error_nxt    = walk_error;
        valid_nxt    = elem.elem_valid;
        is_b_nxt     = elem.elem_is_node_B;
        other_nxt    = elem.elem_other_node;
        type_nxt     = elem.elem_type;
        value_nxt    = elem.elem_value;
        end_bit_nxt  = end_bit;
        next_ptr_nxt = next_ptr;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    cur_node_nxt = node_addr;
                    count_nxt    = '0;
                    empty_nxt    = 1'b0;
                    error_nxt    = 1'b0;
                    hop_nxt      = '0;
                    wait_cnt_nxt = '0;
                    state_nxt    = S_HEAD_WAIT;
                end
            end

            S_HEAD_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_nxt = '0;
                    if (!nodeHeads_out[HEAD_BUILT_BIT]) begin
                        empty_nxt = 1'b1;
                        state_nxt = S_FINISH;
                    end else begin
                        ptr_nxt   = nodeHeads_out[HEAD_PTR_HI:HEAD_PTR_LO];
                        state_nxt = S_ENTRY_WAIT;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end

            S_ENTRY_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_nxt = '0;
                    if (nodeToElement_out[ENT_CUR_HI:ENT_CUR_LO] != cur_node) begin
                        error_nxt = 1'b1;
                        state_nxt = S_FINISH;
                    end else begin
                        is_b_nxt     = nodeToElement_out[ENT_IS_B_BIT];
                        other_nxt    = nodeToElement_out[ENT_OTHER_HI:ENT_OTHER_LO];
                        type_nxt     = nodeToElement_out[ENT_TYPE_HI:ENT_TYPE_LO];
                        value_nxt    = nodeToElement_out[ENT_VALUE_HI:ENT_VALUE_LO];
                        end_bit_nxt  = nodeToElement_out[ENT_END_BIT];
                        next_ptr_nxt = nodeToElement_out[ENT_NEXT_HI:ENT_NEXT_LO];
                        valid_nxt    = 1'b1;
                        state_nxt    = S_EMIT;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end

            S_EMIT: begin
                if (elem.elem_ready) begin
                    valid_nxt = 1'b0;
                    count_nxt = elem_count + COUNT_W'(1);
                    hop_nxt   = hop_inc;
                    // End bit wins over the hop limit so a full-length list ends cleanly.
                    if (end_bit) begin
                        state_nxt = S_FINISH;
                    end else if (hop_inc == HOP_LIMIT) begin
                        error_nxt = 1'b1;
                        state_nxt = S_FINISH;
                    end else begin
                        ptr_nxt   = next_ptr;
                        state_nxt = S_ENTRY_WAIT;
                    end
                end
            end

            S_FINISH: state_nxt = S_IDLE;

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/node_list_walker.md
Name:
node_list_walker

Overview:
- Read-side companion to the node-list builder. Given a node number, it walks that node's linked element list.
- The walk starts at the list head stored in the nodeHeads RAM and follows next pointers through the nodeToElement RAM.
- Each element record is streamed out over a valid/ready handshake.
- The MNA equation-assembly stage uses it to enumerate every element incident on a node. It shares both RAMs with the builder through a port mux that is outside this block.

Parameters:
- RAM_LAT, 2, cycles from an address change to valid RAM q data (this matches the builder's two-step ram_delay).
- MAX_HOPS, 32, maximum list length before the walk is declared cyclic.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a walk; sampled only in IDLE
- node_addr  in  5  node number to walk
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a walk
- list_empty  out  1  valid with done; node was never built (nodeHeads[63]=0)
- walk_error  out  1  valid with done; cyclic list or corrupt entry
- elem_count  out  6  number of elements emitted; valid with done
- nodeHeads_addr  out  5  nodeHeads read address
- nodeHeads_wren  out  1  tied 0
- nodeHeads_out  in  64  nodeHeads q
- nodeToElement_addr  out  5  nodeToElement read address
- nodeToElement_wren  out  1  tied 0
- nodeToElement_out  in  64  nodeToElement q
- elem_valid  out  1  element record is valid
- elem_ready  in  1  consumer accepts the record
- elem_is_node_B  out  1  entry bit 44
- elem_other_node  out  5  entry bits 43:39
- elem_type  out  2  entry bits 33:32
- elem_value  out  32  entry bits 31:0, float

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0, including both addresses, elem_count and the elem_* fields.
- Internal registers: cur_node, ptr[4:0], hop[5:0], wait counter.
- IDLE: on start=1, latch node_addr into cur_node, drive nodeHeads_addr=node_addr, clear elem_count, list_empty, walk_error and hop, then go to HEAD_WAIT.
- HEAD_WAIT: hold the address for RAM_LAT cycles, then sample nodeHeads_out.
  - If bit63=0: list_empty=1, go to FINISH.
  - Else: ptr=bits[46:42], nodeToElement_addr=ptr, go to ENTRY_WAIT.
- ENTRY_WAIT: hold the address for RAM_LAT cycles, then sample nodeToElement_out.
  - If bits[38:34] != cur_node: walk_error=1, go to FINISH.
  - Else: register the elem_* fields, plus end-bit 63 and next-pointer 62:58 internally, set elem_valid=1, go to EMIT.
- EMIT: elem_valid and the elem_* fields stay stable until elem_ready=1. On that handshake cycle:
  - elem_valid drops to 0 and elem_count and hop increment.
  - If the end bit is set: go to FINISH.
  - Else if hop+1 == MAX_HOPS: walk_error=1, go to FINISH.
  - Else: ptr=next, nodeToElement_addr=next, go to ENTRY_WAIT.
- FINISH: done=1 for exactly one cycle, then IDLE. list_empty, walk_error and elem_count hold until the next accepted start.
- start outside IDLE is ignored; no queueing.
- Latency with RAM_LAT=2 and elem_ready tied high:
  - first elem_valid 5 cycles after the start cycle;
  - each later element 3 cycles after the previous handshake;
  - done 1 cycle after the last handshake.
- Boundaries:
  - A single-element list (end bit set at the head entry) gives count 1.
  - A list of exactly MAX_HOPS elements whose last entry has the end bit set finishes cleanly without error: the end check takes priority over the hop check.
  - ptr 31 is a legal address; there is no wrap arithmetic on ptr.
  - elem_count is 6 bits so that 32 is representable.
- Reset mid-walk aborts immediately to IDLE with no done pulse. RAM contents are untouched because both wren outputs are always 0.

Decomposition:
- Shared package holds the field-position constants for both RAM layouts: nodeHeads built bit 63 and head field 46:42; nodeToElement end bit 63, next 62:58, node-side bit 44, other node 43:39, current node 38:34, type 33:32, value 31:0. It also holds the element-type codes (00 V-source, 01 I-source, 10 resistor) so the builder and walker agree.
- No sub-module: a single FSM with a small wait counter.

Test Plan:
- Node 3 never built (nodeHeads[3]=0), start -> done with list_empty=1, elem_count=0, elem_valid never asserted.
- Node 1 with a head at entry 0 and chain 0->2->5 (entry 5 end bit set), elem_ready=1 -> three records in order 0,2,5 with the correct other_node/type/value, elem_count=3, first elem_valid 5 cycles after start.
- Same list with elem_ready held low for 4 cycles on the 2nd record -> record held stable, no duplication, elem_count=3.
- Cyclic chain 4->7->4 -> after 32 handshakes done with walk_error=1, elem_count=32.
- Entry whose current-node field is 9 while walking node 1 -> walk_error=1 with no record emitted for that entry; a start pulsed while busy is ignored; reset asserted during ENTRY_WAIT -> IDLE, all outputs 0, no done pulse.
